// File: rtl/maze_pkg.sv
// Shared constants, types and neighbour helpers for the 16x16 maze solver.
package maze_pkg;

    localparam int unsigned MAZE_DIM    = 16;
    localparam int unsigned COORD_W     = 4;
    localparam int unsigned DIR_W       = 2;
    localparam int unsigned STACK_DEPTH = MAZE_DIM * MAZE_DIM;
    localparam int unsigned SP_W        = 9;
    localparam int unsigned IDX_W       = 8;

    localparam logic [DIR_W-1:0] DIR_RIGHT = 2'd0;
    localparam logic [DIR_W-1:0] DIR_DOWN  = 2'd1;
    localparam logic [DIR_W-1:0] DIR_LEFT  = 2'd2;
    localparam logic [DIR_W-1:0] DIR_UP    = 2'd3;

    localparam logic [COORD_W-1:0] MAX_COORD = COORD_W'(MAZE_DIM - 1);
    localparam logic [COORD_W-1:0] START_X   = 4'd0;
    localparam logic [COORD_W-1:0] START_Y   = 4'd0;
    localparam logic [COORD_W-1:0] TARGET_X  = 4'd15;
    localparam logic [COORD_W-1:0] TARGET_Y  = 4'd15;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MARK,
        ST_CHECK,
        ST_WAIT,
        ST_POP,
        ST_REPLAY,
        ST_DONE,
        ST_FAIL
    } state_t;

    typedef struct packed {
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
    } coord_t;

    typedef struct packed {
        logic   valid;
        coord_t pos;
    } step_t;

    localparam coord_t START_POS  = {START_X, START_Y};
    localparam coord_t TARGET_POS = {TARGET_X, TARGET_Y};

    // Neighbour of c in direction d; valid is low when the move leaves the grid.
    function automatic step_t step_toward(input coord_t c, input logic [DIR_W-1:0] d);
        step_t s;
        s.valid = 1'b1;
        s.pos   = c;
        case (d)
            DIR_RIGHT: begin
                s.valid = (c.x != MAX_COORD);
                s.pos.x = c.x + 4'd1;
            end
            DIR_DOWN: begin
                s.valid = (c.y != MAX_COORD);
                s.pos.y = c.y + 4'd1;
            end
            DIR_LEFT: begin
                s.valid = (c.x != 4'd0);
                s.pos.x = c.x - 4'd1;
            end
            default: begin
                s.valid = (c.y != 4'd0);
                s.pos.y = c.y - 4'd1;
            end
        endcase
        return s;
    endfunction

    // Undo a recorded move d: step from c opposite to d.
    function automatic coord_t step_back(input coord_t c, input logic [DIR_W-1:0] d);
        coord_t p;
        p = c;
        case (d)
            DIR_RIGHT: p.x = c.x - 4'd1;
            DIR_DOWN:  p.y = c.y - 4'd1;
            DIR_LEFT:  p.x = c.x + 4'd1;
            default:   p.y = c.y + 4'd1;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/dir_stack.sv
// 256x2-bit move-history LIFO with a combinational top and an indexed replay read port.
module dir_stack
    import maze_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             push,
    input  logic             pop,
    input  logic [DIR_W-1:0] push_dir,
    output logic [DIR_W-1:0] top_dir,
    output logic [SP_W-1:0]  sp,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [DIR_W-1:0] rd_dir
);

    logic [DIR_W-1:0] entries [STACK_DEPTH];
    logic [IDX_W-1:0] top_idx;

    // Each cell is pushed at most once, so sp stays below STACK_DEPTH.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sp <= '0;
        end else if (clear) begin
            sp <= '0;
        end else if (push) begin
            sp <= sp + SP_W'(1);
        end else if (pop && (sp != '0)) begin
            sp <= sp - SP_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            entries[sp[IDX_W-1:0]] <= push_dir;
        end
    end

    assign top_idx = IDX_W'(sp - SP_W'(1));
    assign top_dir = entries[top_idx];
    assign rd_dir  = entries[rd_idx];

endmodule

// File: rtl/maze_solver_ctrl.sv
// Depth-first maze search controller: marks visited cells, backtracks via the
// direction stack, and replays the found path one move per cycle.
module maze_solver_ctrl
    import maze_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    output logic               mem_rd,
    output logic               mem_wr,
    output logic [COORD_W-1:0] mem_x,
    output logic [COORD_W-1:0] mem_y,
    output logic               mem_din,
    input  logic               mem_dout,
    output logic               busy,
    output logic               done,
    output logic               fail,
    output logic               path_valid,
    output logic [DIR_W-1:0]   path_dir
);

    state_t           state_q, state_d;
    coord_t           cur_q, cur_d;
    logic [DIR_W-1:0] dir_q, dir_d;
    logic [IDX_W-1:0] idx_q, idx_d;

    logic             stk_push, stk_pop, stk_clear;
    logic [DIR_W-1:0] top_dir, rd_dir;
    logic [SP_W-1:0]  sp;

    step_t            nbr, nxt_nbr;
    coord_t           back;

    logic             rd_d, wr_d, busy_d, done_d, fail_d, pv_d;
    coord_t           addr_d;
    logic [DIR_W-1:0] pd_d;

    dir_stack u_stack (
        .clk      (clk),
        .rst      (rst),
        .clear    (stk_clear),
        .push     (stk_push),
        .pop      (stk_pop),
        .push_dir (dir_q),
        .top_dir  (top_dir),
        .sp       (sp),
        .rd_idx   (idx_d),
        .rd_dir   (rd_dir)
    );

    assign nbr  = step_toward(cur_q, dir_q);
    assign back = step_back(cur_q, top_dir);

    // Next-state and search datapath.
    always_comb begin
        state_d   = state_q;
        cur_d     = cur_q;
        dir_d     = dir_q;
        idx_d     = idx_q;
        stk_push  = 1'b0;
        stk_pop   = 1'b0;
        stk_clear = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE, ST_FAIL: begin
                if (start) begin
                    state_d   = ST_MARK;
                    cur_d     = START_POS;
                    dir_d     = DIR_RIGHT;
                    stk_clear = 1'b1;
                end
            end
            ST_MARK: begin
                if (cur_q == TARGET_POS) begin
                    idx_d   = '0;
                    state_d = (sp == '0) ? ST_DONE : ST_REPLAY;
                end else begin
                    dir_d   = DIR_RIGHT;
                    state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (nbr.valid) begin
                    state_d = ST_WAIT;
                end else if (dir_q == DIR_UP) begin
                    state_d = ST_POP;
                end else begin
                    dir_d = dir_q + 2'd1;
                end
            end
            ST_WAIT: begin
                if (!mem_dout) begin
                    stk_push = 1'b1;
                    cur_d    = nbr.pos;
                    state_d  = ST_MARK;
                end else if (dir_q == DIR_UP) begin
                    state_d = ST_POP;
                end else begin
                    dir_d   = dir_q + 2'd1;
                    state_d = ST_CHECK;
                end
            end
            ST_POP: begin
                if (sp == '0) begin
                    state_d = ST_FAIL;
                end else begin
                    stk_pop = 1'b1;
                    cur_d   = back;
                    // A parent whose last tried move was UP has no directions left.
                    if (top_dir != DIR_UP) begin
                        dir_d   = top_dir + 2'd1;
                        state_d = ST_CHECK;
                    end
                end
            end
            ST_REPLAY: begin
                if ((SP_W'(idx_q) + SP_W'(1)) >= sp) begin
                    state_d = ST_DONE;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign nxt_nbr = step_toward(cur_d, dir_d);

    // Outputs for the upcoming state, registered alongside it.
    always_comb begin
        rd_d   = 1'b0;
        wr_d   = 1'b0;
        addr_d = '0;
        pv_d   = 1'b0;
        pd_d   = '0;
        busy_d = 1'b1;
        done_d = 1'b0;
        fail_d = 1'b0;
        case (state_d)
            ST_IDLE: busy_d = 1'b0;
            ST_DONE: begin
                busy_d = 1'b0;
                done_d = 1'b1;
            end
            ST_FAIL: begin
                busy_d = 1'b0;
                fail_d = 1'b1;
            end
            ST_MARK: begin
                wr_d   = 1'b1;
                addr_d = cur_d;
            end
            ST_CHECK: begin
                if (nxt_nbr.valid) begin
                    rd_d   = 1'b1;
                    addr_d = nxt_nbr.pos;
                end
            end
            ST_REPLAY: begin
                pv_d = 1'b1;
                pd_d = rd_dir;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cur_q      <= START_POS;
            dir_q      <= DIR_RIGHT;
            idx_q      <= '0;
            mem_rd     <= 1'b0;
            mem_wr     <= 1'b0;
            mem_x      <= '0;
            mem_y      <= '0;
            mem_din    <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            fail       <= 1'b0;
            path_valid <= 1'b0;
            path_dir   <= '0;
        end else begin
            state_q    <= state_d;
            cur_q      <= cur_d;
            dir_q      <= dir_d;
            idx_q      <= idx_d;
            mem_rd     <= rd_d;
            mem_wr     <= wr_d;
            mem_x      <= addr_d.x;
            mem_y      <= addr_d.y;
            mem_din    <= 1'b1;
            busy       <= busy_d;
            done       <= done_d;
            fail       <= fail_d;
            path_valid <= pv_d;
            path_dir   <= pd_d;
        end
    end

endmodule

// File: tb/tb_maze_solver_ctrl.sv
// Directed bench for maze_solver_ctrl: maze memory model, bus monitor and path checks.
module tb_maze_solver_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       mem_rd, mem_wr, mem_din;
    logic [3:0] mem_x, mem_y;
    logic       mem_dout = 1'b0;
    logic       busy, done, fail, path_valid;
    logic [1:0] path_dir;

    logic       maze [256];
    logic       vis  [256];
    logic [1:0] path [$];
    logic [1:0] exp_path [$];

    int n_vec = 0;
    int n_err = 0;
    int n_wr, n_rd, viol, last_pv, done_cyc;

    maze_solver_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .mem_rd     (mem_rd),
        .mem_wr     (mem_wr),
        .mem_x      (mem_x),
        .mem_y      (mem_y),
        .mem_din    (mem_din),
        .mem_dout   (mem_dout),
        .busy       (busy),
        .done       (done),
        .fail       (fail),
        .path_valid (path_valid),
        .path_dir   (path_dir)
    );

    always #5 clk = ~clk;

    // Maze memory: captures on the edge ending the strobe, read data valid next cycle.
    always @(posedge clk) begin
        if (mem_wr) maze[{mem_y, mem_x}] = 1'b1;
        if (mem_rd) mem_dout <= maze[{mem_y, mem_x}];
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
        n_vec++;
        if (got !== expv) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, expv);
        end
    endtask

    function automatic bit has_vis_nbr(input int x, input int y);
        int i;
        i = y * 16 + x;
        return (x > 0 && vis[i-1]) || (x < 15 && vis[i+1]) ||
               (y > 0 && vis[i-16]) || (y < 15 && vis[i+16]);
    endfunction

    task automatic fill(input logic v);
        for (int i = 0; i < 256; i++) maze[i] = v;
    endtask

    task automatic load_corridor();
        fill(1'b1);
        for (int i = 0; i < 16; i++) begin
            maze[i]          = 1'b0;
            maze[i * 16 + 15] = 1'b0;
        end
    endtask

    task automatic load_deadend();
        fill(1'b1);
        for (int i = 0; i < 4; i++) maze[i] = 1'b0;
        for (int y = 1; y < 16; y++) maze[y * 16] = 1'b0;
        for (int x = 0; x < 16; x++) maze[240 + x] = 1'b0;
    endtask

    task automatic load_blocked();
        fill(1'b0);
        maze[1]  = 1'b1;
        maze[16] = 1'b1;
    endtask

    task automatic make_exp(input int n1, input logic [1:0] d1, input int n2, input logic [1:0] d2);
        exp_path.delete();
        for (int i = 0; i < n1; i++) exp_path.push_back(d1);
        for (int i = 0; i < n2; i++) exp_path.push_back(d2);
    endtask

    task automatic sample(input int cyc);
        if (mem_rd && mem_wr) viol++;
        if (!mem_rd && !mem_wr && (mem_x != 4'd0 || mem_y != 4'd0)) viol++;
        if (mem_wr && !mem_din) viol++;
        if (mem_rd && !has_vis_nbr(int'(mem_x), int'(mem_y))) viol++;
        if (mem_wr) begin
            n_wr++;
            vis[{mem_y, mem_x}] = 1'b1;
        end
        if (mem_rd) n_rd++;
        if (path_valid) begin
            path.push_back(path_dir);
            last_pv = cyc;
        end
        if (done && done_cyc < 0) done_cyc = cyc;
    endtask

    // Starts a search and follows it cycle by cycle; optionally pokes start while
    // busy or asserts rst in the cycle after a read strobe.
    task automatic run(input string tag, input bit poke, input bit rst_in_wait);
        bit poked;
        bit ended;
        n_wr = 0; n_rd = 0; viol = 0; last_pv = -1; done_cyc = -1;
        poked = 1'b0; ended = 1'b0;
        path.delete();
        for (int i = 0; i < 256; i++) vis[i] = 1'b0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk({tag, "_first_wr"}, {busy, mem_wr, mem_rd, mem_x, mem_y}, {1'b1, 1'b1, 1'b0, 8'h00});
        for (int cyc = 0; cyc < 3000; cyc++) begin
            sample(cyc);
            if (done || fail) begin
                ended = 1'b1;
                break;
            end
            if (rst_in_wait && mem_rd) begin
                @(posedge clk); #1;
                rst = 1'b1;
                #1;
                chk({tag, "_rst_in_wait"},
                    {mem_rd, mem_wr, mem_x, mem_y, mem_din, busy, done, fail, path_valid, path_dir},
                    32'h0);
                return;
            end
            if (poke && !poked && mem_rd && n_rd == 5) begin
                start = 1'b1;
                poked = 1'b1;
            end
            @(posedge clk); #1;
            start = 1'b0;
        end
        chk({tag, "_finished"}, ended, 1'b1);
    endtask

    task automatic check_path(input string tag);
        int bad;
        bad = 0;
        chk({tag, "_path_len"}, path.size(), exp_path.size());
        if (path.size() == exp_path.size()) begin
            for (int i = 0; i < path.size(); i++) if (path[i] !== exp_path[i]) bad++;
        end
        chk({tag, "_path_dirs_bad"}, bad, 0);
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs",
            {mem_rd, mem_wr, mem_x, mem_y, mem_din, busy, done, fail, path_valid, path_dir}, 32'h0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("idle_outputs", {mem_rd, mem_wr, busy, done, fail, path_valid}, 6'h0);

        // Corridor: right along row 0, then down column 15.
        load_corridor();
        run("corr", 1'b0, 1'b0);
        make_exp(15, 2'd0, 15, 2'd1);
        chk("corr_status", {done, fail, busy}, 3'b100);
        chk("corr_wr", n_wr, 31);
        chk("corr_rd", n_rd, 30);
        chk("corr_viol", viol, 0);
        chk("corr_done_after_pv", done_cyc - last_pv, 1);
        check_path("corr");
        repeat (3) @(posedge clk);
        #1;
        chk("corr_done_held", {done, path_valid, busy}, 3'b100);

        // Dead-end branch on row 0, real route via column 0 and row 15.
        load_deadend();
        run("dead", 1'b0, 1'b0);
        make_exp(15, 2'd1, 15, 2'd0);
        chk("dead_status", {done, fail, busy}, 3'b100);
        chk("dead_wr", n_wr, 34);
        chk("dead_rd", n_rd, 54);
        chk("dead_viol", viol, 0);
        check_path("dead");

        // Start cell boxed in.
        load_blocked();
        run("blk", 1'b0, 1'b0);
        chk("blk_status", {done, fail, busy}, 3'b010);
        chk("blk_wr", n_wr, 1);
        chk("blk_rd", n_rd, 2);
        chk("blk_pv", path.size(), 0);
        chk("blk_viol", viol, 0);
        repeat (2) @(posedge clk);
        #1;
        chk("blk_fail_held", {fail, busy}, 2'b10);

        // Reset during WAIT, then a clean rerun on a reloaded corridor.
        load_corridor();
        run("rstw", 1'b0, 1'b1);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        chk("rstw_idle", {busy, done, fail, mem_rd, mem_wr}, 5'h0);
        load_corridor();
        run("rerun", 1'b0, 1'b0);
        make_exp(15, 2'd0, 15, 2'd1);
        chk("rerun_status", {done, fail, busy}, 3'b100);
        chk("rerun_viol", viol, 0);
        check_path("rerun");

        // start pulsed mid-search must be ignored.
        load_corridor();
        run("poke", 1'b1, 1'b0);
        chk("poke_status", {done, fail, busy}, 3'b100);
        chk("poke_wr", n_wr, 31);
        chk("poke_rd", n_rd, 30);
        check_path("poke");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
